// File: rtl/krv_test_monitor_if.sv
// Test-monitor bundle: program-side stimulus in, pass/fail status out.
interface krv_test_monitor_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_END_PC = 2,
   parameter int CNT_WIDTH  = 20
);
   logic                             start;
   logic                             clear;
   logic [ADDR_WIDTH-1:0]            dec_pc;
   logic                             dec_pc_valid;
   logic [NUM_END_PC*ADDR_WIDTH-1:0] end_pc_vec;
   logic [NUM_END_PC-1:0]            end_pc_en;
   logic [DATA_WIDTH-1:0]            result_reg;
   logic [DATA_WIDTH-1:0]            pass_value;
   logic                             test_busy;
   logic                             test_done;
   logic                             test_pass;
   logic                             test_fail;
   logic                             test_timeout;
   logic [2:0]                       hit_idx;
   logic [CNT_WIDTH-1:0]             cycle_cnt;
   logic [ADDR_WIDTH-1:0]            end_pc;
   logic [31:0]                      pc_sig;

   modport master (
      output start, clear, dec_pc, dec_pc_valid,
      output end_pc_vec, end_pc_en, result_reg, pass_value,
      input  test_busy, test_done, test_pass, test_fail,
      input  test_timeout, hit_idx, cycle_cnt, end_pc, pc_sig
   );

   modport slave (
      input  start, clear, dec_pc, dec_pc_valid,
      input  end_pc_vec, end_pc_en, result_reg, pass_value,
      output test_busy, test_done, test_pass, test_fail,
      output test_timeout, hit_idx, cycle_cnt, end_pc, pc_sig
   );
endinterface

// File: rtl/krv_test_monitor.sv
// End-of-test pass/fail detector with cycle watchdog for krv_c programs.
// Optional PC signature enabled by defining KRV_TEST_MON_SIG_EN.
module krv_test_monitor #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_END_PC     = 2,
   parameter int CNT_WIDTH      = 20,
   parameter int TIMEOUT_CYCLES = 80000,
   parameter int SETTLE_CYCLES  = 1
) (
   input logic            cpu_clk,
   input logic            cpu_rstn,
   krv_test_monitor_if.slave mon
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [3:0]            settle_q, settle_d;
   logic                  match_q;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  fail_q, fail_d;
   logic                  tmo_q, tmo_d;
   logic [2:0]            idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] endpc_q, endpc_d;

   logic                  match_any;
   logic                  match_now;
   logic [2:0]            hit_sel;
   logic                  hit;

   // Scan high-to-low so the lowest matching slot wins.
   always_comb begin
      match_any = 1'b0;
      hit_sel   = 3'd0;
      for (int i = NUM_END_PC - 1; i >= 0; i--) begin
         if (mon.end_pc_en[i] &&
             mon.dec_pc == mon.end_pc_vec[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            match_any = 1'b1;
            hit_sel   = 3'(i);
         end
      end
   end

   assign match_now = mon.dec_pc_valid && match_any;
   assign hit       = match_now && !match_q;

`ifdef KRV_TEST_MON_SIG_EN
   logic [31:0] sig_q, sig_d;
   logic [31:0] pc32;

   assign pc32 = 32'(mon.dec_pc);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      done_d   = done_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      tmo_d    = tmo_q;
      idx_d    = idx_q;
      endpc_d  = endpc_q;
`ifdef KRV_TEST_MON_SIG_EN
      sig_d    = sig_q;
`endif
      if (mon.clear) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         settle_d = '0;
         done_d   = 1'b0;
         pass_d   = 1'b0;
         fail_d   = 1'b0;
         tmo_d    = 1'b0;
         idx_d    = '0;
         endpc_d  = '0;
`ifdef KRV_TEST_MON_SIG_EN
         sig_d    = '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (mon.start) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  done_d  = 1'b0;
                  pass_d  = 1'b0;
                  fail_d  = 1'b0;
                  tmo_d   = 1'b0;
                  idx_d   = '0;
                  endpc_d = '0;
`ifdef KRV_TEST_MON_SIG_EN
                  sig_d   = '0;
`endif
               end
            end
            S_RUN: begin
`ifdef KRV_TEST_MON_SIG_EN
               if (mon.dec_pc_valid)
                  sig_d = {sig_q[30:0], sig_q[31]} ^ pc32;
`endif
               if (hit) begin
                  state_d  = S_SETTLE;
                  idx_d    = hit_sel;
                  endpc_d  = mon.dec_pc;
                  settle_d = SETTLE_LOAD;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  tmo_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SETTLE: begin
               if (settle_q == 4'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (mon.result_reg == mon.pass_value);
                  fail_d  = (mon.result_reg != mon.pass_value);
               end else begin
                  settle_d = settle_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         settle_q <= '0;
         match_q  <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         tmo_q    <= 1'b0;
         idx_q    <= '0;
         endpc_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         match_q  <= match_now;
         done_q   <= done_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         tmo_q    <= tmo_d;
         idx_q    <= idx_d;
         endpc_q  <= endpc_d;
      end
   end

`ifdef KRV_TEST_MON_SIG_EN
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) sig_q <= '0;
      else           sig_q <= sig_d;
   end

   assign mon.pc_sig = sig_q;
`else
   assign mon.pc_sig = 32'd0;
`endif

   assign mon.test_busy    = (state_q == S_RUN) || (state_q == S_SETTLE);
   assign mon.test_done    = done_q;
   assign mon.test_pass    = pass_q;
   assign mon.test_fail    = fail_q;
   assign mon.test_timeout = tmo_q;
   assign mon.hit_idx      = idx_q;
   assign mon.cycle_cnt    = cnt_q;
   assign mon.end_pc       = endpc_q;

endmodule

// File: tb/tb_krv_test_monitor.sv
// Directed-vector bench for krv_test_monitor.
// Signature expectations follow KRV_TEST_MON_SIG_EN.
module tb_krv_test_monitor;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int NE  = 2;
   localparam int CW  = 20;
   localparam int TMO = 120;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   krv_test_monitor_if #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .NUM_END_PC(NE), .CNT_WIDTH(CW)
   ) mif ();

   krv_test_monitor #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_END_PC(NE),
      .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(1)
   ) dut (
      .cpu_clk (clk),
      .cpu_rstn(rstn),
      .mon     (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear();
      mif.clear = 1'b1;
      tick(1);
      mif.clear = 1'b0;
   endtask

   task automatic do_start();
      mif.start = 1'b1;
      tick(1);
      mif.start = 1'b0;
   endtask

   task automatic present(input logic [31:0] pc);
      mif.dec_pc       = pc;
      mif.dec_pc_valid = 1'b1;
      tick(1);
      mif.dec_pc_valid = 1'b0;
   endtask

   function automatic logic [31:0] rol_x(input logic [31:0] s,
                                         input logic [31:0] pc);
      return {s[30:0], s[31]} ^ pc;
   endfunction

   logic [31:0] sig_e;
   logic        sig_on;

   initial begin
      checks = 0;
      errors = 0;
`ifdef KRV_TEST_MON_SIG_EN
      sig_on = 1'b1;
`else
      sig_on = 1'b0;
`endif
      rstn             = 1'b0;
      mif.start        = 1'b0;
      mif.clear        = 1'b0;
      mif.dec_pc       = '0;
      mif.dec_pc_valid = 1'b0;
      mif.end_pc_vec   = {32'h0, 32'h48};
      mif.end_pc_en    = 2'b01;
      mif.result_reg   = 32'd1;
      mif.pass_value   = 32'd1;
      tick(3);
      chk("rst_busy", 64'(mif.test_busy), 64'd0);
      chk("rst_done", 64'(mif.test_done), 64'd0);
      chk("rst_cnt",  64'(mif.cycle_cnt), 64'd0);
      chk("rst_sig",  64'(mif.pc_sig),    64'd0);
      rstn = 1'b1;
      tick(2);

      // pass at RUN cycle 100
      do_start();
      chk("run_busy", 64'(mif.test_busy), 64'd1);
      chk("run_cnt0", 64'(mif.cycle_cnt), 64'd0);
      tick(100);
      chk("run_cnt100", 64'(mif.cycle_cnt), 64'd100);
      present(32'h48);
      chk("settle_done", 64'(mif.test_done), 64'd0);
      chk("settle_busy", 64'(mif.test_busy), 64'd1);
      tick(1);
      chk("pass_done", 64'(mif.test_done), 64'd1);
      chk("pass_pass", 64'(mif.test_pass), 64'd1);
      chk("pass_fail", 64'(mif.test_fail), 64'd0);
      chk("pass_idx",  64'(mif.hit_idx),   64'd0);
      chk("pass_pc",   64'(mif.end_pc),    64'h48);
      chk("pass_cnt",  64'(mif.cycle_cnt), 64'd100);
      chk("pass_busy", 64'(mif.test_busy), 64'd0);

      // start ignored in DONE
      do_start();
      chk("done_hold", 64'(mif.test_done), 64'd1);
      chk("done_busy", 64'(mif.test_busy), 64'd0);
      chk("done_cnt",  64'(mif.cycle_cnt), 64'd100);
      do_clear();
      chk("clr_done", 64'(mif.test_done), 64'd0);
      chk("clr_pass", 64'(mif.test_pass), 64'd0);
      chk("clr_pc",   64'(mif.end_pc),    64'd0);
      chk("clr_cnt",  64'(mif.cycle_cnt), 64'd0);

      // fail with both slots equal: slot 0 wins
      mif.end_pc_vec = {32'h80, 32'h80};
      mif.end_pc_en  = 2'b11;
      mif.result_reg = 32'd5;
      do_start();
      tick(3);
      present(32'h80);
      tick(1);
      chk("fail_fail", 64'(mif.test_fail), 64'd1);
      chk("fail_pass", 64'(mif.test_pass), 64'd0);
      chk("fail_idx",  64'(mif.hit_idx),   64'd0);
      chk("fail_cnt",  64'(mif.cycle_cnt), 64'd3);
      do_clear();

      // slot 1 only
      mif.end_pc_vec = {32'h90, 32'h80};
      mif.end_pc_en  = 2'b10;
      mif.result_reg = 32'd1;
      do_start();
      present(32'h80);
      present(32'h90);
      tick(1);
      chk("s1_idx",  64'(mif.hit_idx), 64'd1);
      chk("s1_pc",   64'(mif.end_pc),  64'h90);
      chk("s1_pass", 64'(mif.test_pass), 64'd1);
      do_clear();
      chk("s1_clr_idx", 64'(mif.hit_idx), 64'd0);

      // timeout with no slots enabled
      mif.end_pc_vec = {32'h0, 32'h48};
      mif.end_pc_en  = 2'b00;
      do_start();
      present(32'h48);
      tick(TMO - 2);
      chk("to_pre_done", 64'(mif.test_done), 64'd0);
      chk("to_pre_cnt",  64'(mif.cycle_cnt), 64'(TMO - 1));
      tick(1);
      chk("to_done", 64'(mif.test_done),    64'd1);
      chk("to_tmo",  64'(mif.test_timeout), 64'd1);
      chk("to_pass", 64'(mif.test_pass),    64'd0);
      chk("to_fail", 64'(mif.test_fail),    64'd0);
      chk("to_cnt",  64'(mif.cycle_cnt),    64'(TMO - 1));
      do_clear();

      // hit on the last cycle beats timeout
      mif.end_pc_en = 2'b01;
      do_start();
      tick(TMO - 1);
      present(32'h48);
      chk("last_tmo",  64'(mif.test_timeout), 64'd0);
      chk("last_busy", 64'(mif.test_busy),    64'd1);
      tick(1);
      chk("last_pass", 64'(mif.test_pass),    64'd1);
      chk("last_tmo2", 64'(mif.test_timeout), 64'd0);
      do_clear();

      // PC parked on end address across start
      mif.dec_pc       = 32'h48;
      mif.dec_pc_valid = 1'b1;
      tick(2);
      do_start();
      tick(3);
      chk("park_busy", 64'(mif.test_busy), 64'd1);
      chk("park_done", 64'(mif.test_done), 64'd0);
      mif.dec_pc = 32'h4C;
      tick(1);
      mif.dec_pc = 32'h48;
      tick(1);
      mif.dec_pc_valid = 1'b0;
      tick(1);
      chk("park_hit", 64'(mif.test_pass), 64'd1);
      chk("park_cnt", 64'(mif.cycle_cnt), 64'd4);
      do_clear();

      // clear in SETTLE, and clear beats start and hit
      do_start();
      present(32'h48);
      chk("cs_busy", 64'(mif.test_busy), 64'd1);
      mif.clear = 1'b1;
      mif.start = 1'b1;
      tick(1);
      chk("cs_busy2", 64'(mif.test_busy), 64'd0);
      chk("cs_done",  64'(mif.test_done), 64'd0);
      chk("cs_pc",    64'(mif.end_pc),    64'd0);
      chk("cs_cnt",   64'(mif.cycle_cnt), 64'd0);
      mif.start        = 1'b0;
      mif.dec_pc       = 32'h4C;
      mif.dec_pc_valid = 1'b1;
      tick(1);
      mif.dec_pc = 32'h48;
      tick(1);
      mif.clear        = 1'b0;
      mif.dec_pc_valid = 1'b0;
      chk("cw_busy", 64'(mif.test_busy), 64'd0);
      chk("cw_pc",   64'(mif.end_pc),    64'd0);

      // signature
      mif.end_pc_en = 2'b00;
      do_start();
      sig_e = '0;
      present(32'h0);
      sig_e = rol_x(sig_e, 32'h0);
      chk("sig0", 64'(mif.pc_sig), sig_on ? 64'(sig_e) : 64'd0);
      present(32'h4);
      sig_e = rol_x(sig_e, 32'h4);
      chk("sig1", 64'(mif.pc_sig), sig_on ? 64'(sig_e) : 64'd0);
      present(32'h8);
      sig_e = rol_x(sig_e, 32'h8);
      chk("sig2", 64'(mif.pc_sig), sig_on ? 64'(sig_e) : 64'd0);
      present(32'h1234);
      sig_e = rol_x(sig_e, 32'h1234);
      chk("sig3", 64'(mif.pc_sig), sig_on ? 64'(sig_e) : 64'd0);
      do_clear();
      chk("sig_clr", 64'(mif.pc_sig), 64'd0);

      // async reset mid-RUN
      mif.end_pc_en = 2'b01;
      do_start();
      tick(5);
      #2;
      rstn = 1'b0;
      #1;
      chk("ar_busy", 64'(mif.test_busy), 64'd0);
      chk("ar_cnt",  64'(mif.cycle_cnt), 64'd0);
      chk("ar_done", 64'(mif.test_done), 64'd0);
      tick(1);
      rstn = 1'b1;
      tick(1);
      chk("ar_idle", 64'(mif.test_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
